// File: rtl/pwm_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Module   : pwm_pkg                                               |
// | Brief    : Shared PWM frame constants and decoder state type.    |
// | Revision : 1.0                                                   |
// +------------------------------------------------------------------+
package pwm_pkg;

  localparam int PWM_PERIOD = 256;
  localparam int DUTY_WIDTH = 8;
  localparam int TIMEOUT    = 2 * PWM_PERIOD;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_HIGH   = 2'd1,
    ST_LOW    = 2'd2,
    ST_STATIC = 2'd3
  } pwm_dec_state_t;

endpackage
`default_nettype wire

// File: rtl/pwm_channel_decoder.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Module   : pwm_channel_decoder                                   |
// | Brief    : Recovers the duty of one PWM line, one frame at a time.|
// | Revision : 1.0                                                   |
// +------------------------------------------------------------------+
module pwm_channel_decoder #(
  parameter int PWM_PERIOD = pwm_pkg::PWM_PERIOD,
  parameter int DUTY_WIDTH = pwm_pkg::DUTY_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  pwm_in,
  output logic [DUTY_WIDTH-1:0] duty,
  output logic                  valid,
  output logic                  err
);
  import pwm_pkg::*;

  localparam int c_timeout = 2 * PWM_PERIOD;
  localparam int c_cnt_w   = $clog2(2 * PWM_PERIOD) + 1;
  localparam int c_hi_w    = DUTY_WIDTH + 1;

  logic                  r_sync1;
  logic                  r_pwm_s;
  logic                  r_pwm_q;
  logic                  w_rise;
  logic                  w_fall;
  logic                  w_timeout;
  logic [c_cnt_w-1:0]    r_cnt;
  logic [c_hi_w-1:0]     r_hi;
  pwm_dec_state_t        r_state;
  pwm_dec_state_t        w_state_nxt;
  logic [DUTY_WIDTH-1:0] r_duty;
  logic [DUTY_WIDTH-1:0] w_duty_nxt;
  logic                  r_valid;
  logic                  w_valid_nxt;
  logic                  r_err;
  logic                  w_err_nxt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync1 <= 1'b0;
      r_pwm_s <= 1'b0;
      r_pwm_q <= 1'b0;
    end else begin
      r_sync1 <= pwm_in;
      r_pwm_s <= r_sync1;
      r_pwm_q <= r_pwm_s;
    end
  end

  assign w_rise    = r_pwm_s & ~r_pwm_q;
  assign w_fall    = ~r_pwm_s & r_pwm_q;
  assign w_timeout = ~w_rise && (r_cnt == c_cnt_w'(c_timeout - 1));

  // cnt saturates so a dead line cannot wrap back into a valid-looking period
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (w_rise) begin
      r_cnt <= c_cnt_w'(1);
    end else if (r_cnt != c_cnt_w'(c_timeout)) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_hi <= '0;
    end else if (w_rise) begin
      r_hi <= c_hi_w'(1);
    end else if ((r_state == ST_HIGH) && r_pwm_s && !r_hi[DUTY_WIDTH]) begin
      r_hi <= r_hi + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_duty  <= '0;
      r_valid <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_duty  <= w_duty_nxt;
      r_valid <= w_valid_nxt;
      r_err   <= w_err_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_duty_nxt  = r_duty;
    w_valid_nxt = 1'b0;
    w_err_nxt   = 1'b0;
    if (w_timeout && (r_state != ST_STATIC)) begin
      // A line stuck high is something the generator never produces
      w_state_nxt = ST_STATIC;
      w_valid_nxt = 1'b1;
      if (r_pwm_s) begin
        w_duty_nxt = '1;
        w_err_nxt  = 1'b1;
      end else begin
        w_duty_nxt = '0;
      end
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_rise) w_state_nxt = ST_HIGH;
        end
        ST_HIGH: begin
          if (w_fall) w_state_nxt = ST_LOW;
        end
        ST_LOW: begin
          if (w_rise) begin
            w_state_nxt = ST_HIGH;
            if (r_cnt == c_cnt_w'(PWM_PERIOD)) begin
              w_duty_nxt  = r_hi[DUTY_WIDTH-1:0];
              w_valid_nxt = 1'b1;
            end else begin
              w_err_nxt = 1'b1;
            end
          end
        end
        ST_STATIC: begin
          if (w_rise) w_state_nxt = ST_HIGH;
        end
        default: w_state_nxt = ST_IDLE;
      endcase
    end
  end

  assign duty  = r_duty;
  assign valid = r_valid;
  assign err   = r_err;

endmodule
`default_nettype wire

// File: rtl/pwm_rgb_decoder.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Module   : pwm_rgb_decoder                                       |
// | Brief    : Three independent PWM duty decoders for the RGB lines. |
// | Revision : 1.0                                                   |
// +------------------------------------------------------------------+
module pwm_rgb_decoder #(
  parameter int PWM_PERIOD = pwm_pkg::PWM_PERIOD,
  parameter int DUTY_WIDTH = pwm_pkg::DUTY_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  RGB_R,
  input  logic                  RGB_G,
  input  logic                  RGB_B,
  output logic [DUTY_WIDTH-1:0] duty_R,
  output logic [DUTY_WIDTH-1:0] duty_G,
  output logic [DUTY_WIDTH-1:0] duty_B,
  output logic                  valid_R,
  output logic                  valid_G,
  output logic                  valid_B,
  output logic                  err_R,
  output logic                  err_G,
  output logic                  err_B
);
  import pwm_pkg::*;

  pwm_channel_decoder #(
    .PWM_PERIOD (PWM_PERIOD),
    .DUTY_WIDTH (DUTY_WIDTH)
  ) u_dec_r (
    .clk    (clk),
    .rst_n  (rst_n),
    .pwm_in (RGB_R),
    .duty   (duty_R),
    .valid  (valid_R),
    .err    (err_R)
  );

  pwm_channel_decoder #(
    .PWM_PERIOD (PWM_PERIOD),
    .DUTY_WIDTH (DUTY_WIDTH)
  ) u_dec_g (
    .clk    (clk),
    .rst_n  (rst_n),
    .pwm_in (RGB_G),
    .duty   (duty_G),
    .valid  (valid_G),
    .err    (err_G)
  );

  pwm_channel_decoder #(
    .PWM_PERIOD (PWM_PERIOD),
    .DUTY_WIDTH (DUTY_WIDTH)
  ) u_dec_b (
    .clk    (clk),
    .rst_n  (rst_n),
    .pwm_in (RGB_B),
    .duty   (duty_B),
    .valid  (valid_B),
    .err    (err_B)
  );

endmodule
`default_nettype wire
